// File: rtl/sprite_blit.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blit
//  Description : Pipelined sprite renderer for the VGA pixel path. It
//                hit-tests each pixel against a movable sprite and fetches
//                the texel from an external sprite ROM. It composites the
//                texel over the background. It supports animation frames,
//                horizontal flip, integer scaling and a position update that
//                takes effect only on vsync.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_blit #(
   parameter int X_SIZE    = 32,
   parameter int Y_SIZE    = 43,
   parameter int FRAMES    = 4,
   parameter int FRAME_DIV = 8,
   parameter int ADDR_W    = 13,
   localparam int FRAME_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [10:0]        ix,
   input  logic [10:0]        iy,
   input  logic               i_vsync,
   input  logic [10:0]        i_pos_x,
   input  logic [10:0]        i_pos_y,
   input  logic               i_flip,
   input  logic [1:0]         i_scale,
   input  logic               i_anim_en,
   input  logic [7:0]         i_bg_r,
   input  logic [7:0]         i_bg_g,
   input  logic [7:0]         i_bg_b,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [12:0]        rom_data,
   output logic [7:0]         oR,
   output logic [7:0]         oG,
   output logic [7:0]         oB,
   output logic               mask,
   output logic [FRAME_W-1:0] o_frame
);

   localparam int          DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [31:0] C_XS       = 32'(X_SIZE);
   localparam logic [31:0] C_YS       = 32'(Y_SIZE);
   localparam logic [31:0] C_FRAME_SZ = 32'(X_SIZE * Y_SIZE);

   // Active (shadowed) sprite state and animation counters
   logic [10:0]        pos_x_q, pos_x_d;
   logic [10:0]        pos_y_q, pos_y_d;
   logic               flip_q, flip_d;
   logic [1:0]         scale_q, scale_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [FRAME_W-1:0] frame_q, frame_d;

   // Stage 1: address plus delayed hit and background
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic               hit_q, hit_d;
   logic [7:0]         bg_r_q, bg_g_q, bg_b_q;

   // Stage 2: composited output
   logic [7:0]         o_r_q, o_r_d, o_g_q, o_g_d, o_b_q, o_b_d;
   logic               mask_q, mask_d;

   // Hit-test intermediates
   logic [11:0]        dx_full, dy_full;
   logic [1:0]         shift;
   logic [10:0]        dx_s, dy_s, sx;

   // Next active state: the vsync edge latches shadows and steps the animation,
   // and the pixel sampled on that same edge already sees the new values.
   always_comb begin
      pos_x_d = i_vsync ? i_pos_x : pos_x_q;
      pos_y_d = i_vsync ? i_pos_y : pos_y_q;
      flip_d  = i_vsync ? i_flip  : flip_q;
      scale_d = i_vsync ? i_scale : scale_q;
      div_d   = div_q;
      frame_d = frame_q;
      if (i_vsync && i_anim_en) begin
         if (div_q == DIV_W'(FRAME_DIV - 1)) begin
            div_d   = '0;
            frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   // Hit test and texel address; the 12-bit subtraction borrow rejects pixels
   // left of / above the sprite, so a clipped sprite never wraps around.
   always_comb begin
      dx_full = {1'b0, ix} - {1'b0, pos_x_d};
      dy_full = {1'b0, iy} - {1'b0, pos_y_d};
      case (scale_d)
         2'd0:    shift = 2'd0;
         2'd1:    shift = 2'd1;
         default: shift = 2'd2;
      endcase
      dx_s  = dx_full[10:0] >> shift;
      dy_s  = dy_full[10:0] >> shift;
      hit_d = !dx_full[11] && !dy_full[11] &&
              (32'(dx_s) < C_XS) && (32'(dy_s) < C_YS);
      sx    = flip_d ? (11'(X_SIZE - 1) - dx_s) : dx_s;
      rom_addr_d = hit_d ? ADDR_W'(32'(frame_d) * C_FRAME_SZ + 32'(dy_s) * C_XS + 32'(sx))
                         : '0;
   end

   // Composite: opaque texel on a hit wins, nibbles replicated to 8 bits
   always_comb begin
      o_r_d  = bg_r_q;
      o_g_d  = bg_g_q;
      o_b_d  = bg_b_q;
      mask_d = 1'b0;
      if (hit_q && rom_data[0]) begin
         o_r_d  = {rom_data[12:9], rom_data[12:9]};
         o_g_d  = {rom_data[8:5],  rom_data[8:5]};
         o_b_d  = {rom_data[4:1],  rom_data[4:1]};
         mask_d = 1'b1;
      end
   end

   // All state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_x_q    <= '0;
         pos_y_q    <= '0;
         flip_q     <= 1'b0;
         scale_q    <= 2'd0;
         div_q      <= '0;
         frame_q    <= '0;
         rom_addr_q <= '0;
         hit_q      <= 1'b0;
         bg_r_q     <= '0;
         bg_g_q     <= '0;
         bg_b_q     <= '0;
         o_r_q      <= '0;
         o_g_q      <= '0;
         o_b_q      <= '0;
         mask_q     <= 1'b0;
      end else begin
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         flip_q     <= flip_d;
         scale_q    <= scale_d;
         div_q      <= div_d;
         frame_q    <= frame_d;
         rom_addr_q <= rom_addr_d;
         hit_q      <= hit_d;
         bg_r_q     <= i_bg_r;
         bg_g_q     <= i_bg_g;
         bg_b_q     <= i_bg_b;
         o_r_q      <= o_r_d;
         o_g_q      <= o_g_d;
         o_b_q      <= o_b_d;
         mask_q     <= mask_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign oR       = o_r_q;
   assign oG       = o_g_q;
   assign oB       = o_b_q;
   assign mask     = mask_q;
   assign o_frame  = frame_q;

endmodule
`default_nettype wire

// File: doc/sprite_blit.md
# sprite_blit

Parametrised, pipelined sprite renderer for the VGA pixel path. It succeeds the fixed single-frame sprite tables. Per pixel coordinate, it resolves whether the pixel falls inside a movable sprite and fetches the texel from an external synchronous sprite ROM. It outputs sprite colour when the texel is opaque and the background otherwise. It adds animation frames, horizontal flip, integer scaling and tear-free position update.

## Interface
- X_SIZE, 32: sprite width in texels
- Y_SIZE, 43: sprite height in texels
- FRAMES, 4: animation frames stored back-to-back in ROM
- FRAME_DIV, 8: vsync pulses per animation step
- ADDR_W, 13: ROM address width; must satisfy 2^ADDR_W >= FRAMES*X_SIZE*Y_SIZE
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- ix  in  11  current pixel x
- iy  in  11  current pixel y
- i_vsync  in  1  one-cycle frame-start pulse
- i_pos_x  in  11  sprite top-left x (shadow input)
- i_pos_y  in  11  sprite top-left y (shadow input)
- i_flip  in  1  horizontal mirror (shadow input)
- i_scale  in  2  0=1x, 1=2x, 2=4x, 3=4x (shadow input)
- i_anim_en  in  1  animation enable
- i_bg_r, i_bg_g, i_bg_b  in  8 each  background colour for this pixel
- rom_addr  out  ADDR_W  texel address
- rom_data  in  13  texel, one cycle after rom_addr: [12:9] R, [8:5] G, [4:1] B, [0] opaque
- oR, oG, oB  out  8 each  composited colour
- mask  out  1  sprite pixel drawn
- o_frame  out  clog2(FRAMES)  current animation frame

## Operation
- Active registers: pos_x, pos_y, flip, scale. They load from the inputs only on an edge with i_vsync=1, so a frame is never torn.
- Hit test (12-bit subtraction):
  - dx = ix - pos_x, dy = iy - pos_y.
  - Hit iff there is no borrow on either subtraction, (dx >> s) < X_SIZE, and (dy >> s) < Y_SIZE, where s is 0, 1 or 2.
  - No wrap-around: a sprite partly off the right or bottom edge is clipped, never wrapped.
- Texel coordinates:
  - sx = dx >> s, sy = dy >> s.
  - If flip=1, sx = X_SIZE-1-sx.
- Address: rom_addr = frame*X_SIZE*Y_SIZE + sy*X_SIZE + sx. On a miss, rom_addr is 0.
- Composite:
  - If the delayed hit is 1 and rom_data[0]=1: oR={R,R}, oG={G,G}, oB={B,B} (nibble replication, so F gives FF), and mask=1.
  - Otherwise, output the delayed i_bg_* and mask=0.
- Animation:
  - A divider counter counts i_vsync pulses while i_anim_en=1.
  - At FRAME_DIV-1 it wraps to 0 and frame advances; frame goes from FRAMES-1 to 0.
  - While i_anim_en=0, the counter and frame are held, not cleared.
  - A frame change and the shadow latch happen on the same vsync edge.
- Reset (asynchronous, any time, including mid-line): clears all pipeline, active and animation registers. After reset: oR/oG/oB=0, mask=0, rom_addr=0, o_frame=0, divider=0, pos=0, flip=0, scale=1x.

## Timing
- Pipeline:
  - ix, iy and i_bg_* are sampled at edge k.
  - rom_addr and the hit/background delay registers are valid after edge k.
  - The ROM returns rom_data during cycle k+1.
  - oR/oG/oB/mask are registered at edge k+1, giving a fixed 2-cycle latency from coordinate to pixel.
  - The pipeline is fully streaming: one pixel per clock, no stalls.
- The i_vsync edge itself:
  - The pixel sampled on that edge already uses the new position and frame.
  - Values present on the i_pos_*, i_flip and i_scale inputs at that edge are the ones latched.
- o_frame changes after the vsync edge and is registered.
- The first valid output after rst_n deasserts appears 2 edges later.

## Test plan
- Reset and background pass-through:
  - Assert rst_n=0 mid-stream: all outputs go to 0 immediately (asynchronously).
  - After release, with no vsync and the sprite at (0,0) but i_bg=0x12/34/56: an opaque texel at (0,0) is drawn; a transparent texel passes 0x12/34/56 with 2-cycle latency.
- Placement and clipping:
  - pos=(100,50), scale 1x.
  - ix=99 gives mask=0.
  - ix=100, iy=50 gives rom_addr=0.
  - ix=131 gives rom_addr=31.
  - ix=132 gives mask=0.
  - pos_x=1270 and ix=1279 gives addr=9, with no wrap at x<2.
- Flip and scale:
  - flip=1, ix=pos_x gives sx=31.
  - scale=2x: ix=pos_x+63 gives sx=31; ix=pos_x+64 gives a miss.
  - scale code 3 behaves exactly like code 2.
- Animation:
  - anim_en=1, FRAME_DIV=8: o_frame steps 0,1,2,3,0 every 8 vsyncs.
  - Frame 1 at sprite-relative (0,0) gives rom_addr=1376.
  - Dropping anim_en mid-count holds the count; re-enabling resumes from it.
- Tear-free update:
  - Change i_pos_x mid-frame without vsync: rendering is unchanged.
  - Pulse i_vsync: the next sampled pixel uses the new position.
- Colour expansion:
  - rom_data = R=0xA, G=0x5, B=0xF, opaque gives oR=0xAA, oG=0x55, oB=0xFF, mask=1.
